// File: rtl/cbrt_sched_if.sv
// Requester-side bus of cbrt_sched: per-client request handshake and one-hot response pulse.
interface cbrt_sched_if #(
  parameter int N_REQ = 4,
  parameter int W_X   = 8,
  parameter int W_R   = 3
);
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*W_X-1:0] req_x;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ-1:0]     rsp_valid;
  logic [W_R-1:0]       rsp_result;
  logic                 rsp_err;

  modport master (output req_valid, req_x, input req_ready, rsp_valid, rsp_result, rsp_err);
  modport slave  (input req_valid, req_x, output req_ready, rsp_valid, rsp_result, rsp_err);
endinterface

// File: rtl/cbrt_sched.sv
// Round-robin scheduler sharing one cbrt engine between N_REQ requesters.
// Optional one-entry result cache is built in when CBRT_SCHED_CACHE_EN is defined.
module cbrt_sched #(
  parameter int N_REQ  = 4,
  parameter int W_X    = 8,
  parameter int W_R    = 3,
  parameter int WD_CYC = 4
) (
  input  logic           clk,
  input  logic           rst,
  cbrt_sched_if.slave    bus,
  output logic           eng_rst,
  output logic           eng_start,
  output logic [W_X-1:0] eng_x,
  input  logic           eng_busy,
  input  logic [W_R-1:0] eng_result,
  output logic           sched_busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(WD_CYC + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [W_X-1:0] x_q, x_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W_R-1:0] rsp_result_q, rsp_result_d;
  logic           rsp_err_q, rsp_err_d;
  logic           eng_start_q, eng_start_d;
  logic [W_X-1:0] eng_x_q, eng_x_d;

`ifdef CBRT_SCHED_CACHE_EN
  logic           c_valid_q, c_valid_d;
  logic [W_X-1:0] c_x_q, c_x_d;
  logic [W_R-1:0] c_root_q, c_root_d;
`endif

  logic           grant_any;
  logic [PW-1:0]  grant_idx;
  logic [W_X-1:0] grant_x;
  logic           accept;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  assign grant_x = bus.req_x[int'(grant_idx)*W_X +: W_X];
  assign accept  = (state_q == IDLE) && !eng_busy && grant_any && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    x_d          = x_q;
    wd_d         = wd_q;
    rsp_valid_d  = '0;
    rsp_result_d = '0;
    rsp_err_d    = 1'b0;
    eng_start_d  = 1'b0;
    eng_x_d      = '0;
`ifdef CBRT_SCHED_CACHE_EN
    c_valid_d    = c_valid_q;
    c_x_d        = c_x_q;
    c_root_d     = c_root_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d  = grant_idx;
          x_d      = grant_x;
          rr_ptr_d = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
`ifdef CBRT_SCHED_CACHE_EN
          if (c_valid_q && (c_x_q == grant_x)) begin
            state_d      = RESP;
            rsp_result_d = c_root_q;
          end else
`endif
          begin
            state_d     = ISSUE;
            eng_start_d = 1'b1;
            eng_x_d     = grant_x;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        eng_x_d = x_q;
      end
      WAIT_BUSY: begin
        if (eng_busy) begin
          state_d = WAIT_DONE;
          eng_x_d = x_q;
        end else begin
          wd_d = wd_q + WW'(1);
          if (wd_d == WW'(WD_CYC)) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            eng_x_d = x_q;
          end
        end
      end
      WAIT_DONE: begin
        if (eng_busy) begin
          eng_x_d = x_q;
        end else begin
          state_d      = RESP;
          rsp_result_d = eng_result;
`ifdef CBRT_SCHED_CACHE_EN
          c_valid_d    = 1'b1;
          c_x_d        = x_q;
          c_root_d     = eng_result;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        wd_d    = '0;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RESP) rsp_valid_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      x_q          <= '0;
      wd_q         <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_x_q      <= '0;
`ifdef CBRT_SCHED_CACHE_EN
      c_valid_q    <= 1'b0;
      c_x_q        <= '0;
      c_root_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      x_q          <= x_d;
      wd_q         <= wd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      eng_start_q  <= eng_start_d;
      eng_x_q      <= eng_x_d;
`ifdef CBRT_SCHED_CACHE_EN
      c_valid_q    <= c_valid_d;
      c_x_q        <= c_x_d;
      c_root_q     <= c_root_d;
`endif
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign eng_rst        = rst;
  assign eng_start      = eng_start_q;
  assign eng_x          = eng_x_q;
  assign sched_busy     = (state_q != IDLE);
endmodule

// File: doc/cbrt_sched.md
Name: cbrt_sched

Overview:
Round-robin scheduler that shares one cbrt engine between N_REQ requesters. It accepts one request at a time and drives the engine's start/x_i handshake. It watches engine busy, then returns the 3-bit cube root to the winning requester as a one-cycle response pulse. It sits between the client blocks and a single cbrt instance, and owns that instance's start, operand and reset lines.

Parameters:
N_REQ, 4, number of requesters (2..8)
W_X, 8, operand width; must match the engine's x_i
W_R, 3, result width; must match the engine's result
WD_CYC, 4, max cycles to wait for eng_busy to rise after eng_start before flagging an error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request valid
req_x  in  N_REQ*W_X  flattened operands; requester i uses bits [i*W_X +: W_X]
req_ready  out  N_REQ  one-hot accept pulse; the request is taken when req_valid[i] & req_ready[i]
rsp_valid  out  N_REQ  one-hot response pulse to the requester that owns the operation
rsp_result  out  W_R  cube root; valid only while rsp_valid is nonzero
rsp_err  out  1  qualifies rsp_valid; 1 = engine never started (watchdog), rsp_result = 0
eng_rst  out  1  engine reset, equal to rst
eng_start  out  1  engine start
eng_x  out  W_X  engine operand
eng_busy  in  1  engine busy
eng_result  in  W_R  engine result
sched_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; rr_ptr=0; owner=0; watchdog counter=0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, eng_start=0, eng_x=0.
  - eng_rst follows rst, so the engine resets in the same cycle. Reset mid-operation aborts with no response pulse.
- States: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set and eng_busy=0, grant the first set bit searching upward from rr_ptr with wrap-around.
  - req_ready for the grant is combinational, one-hot, and only asserted in IDLE.
  - On accept: latch the operand and owner, set rr_ptr = owner+1 mod N_REQ, go to ISSUE.
  - If eng_busy=1 in IDLE (engine not yet idle after reset), grant nothing.
- ISSUE: eng_start=1 for exactly one cycle, eng_x = latched operand; go to WAIT_BUSY. eng_x holds the latched operand from ISSUE through WAIT_DONE.
- WAIT_BUSY:
  - eng_busy=1 -> WAIT_DONE.
  - Otherwise increment the watchdog. When it reaches WD_CYC, go to RESP with the error flag set.
- WAIT_DONE: stay while eng_busy=1. On eng_busy=0, capture eng_result into rsp_result and go to RESP.
- RESP: rsp_valid[owner]=1 for one cycle, rsp_err = error flag; clear the flag and watchdog; go to IDLE.
- Throughput: at most one response in flight; a new accept is earliest in the cycle after RESP.
- Latency, no cache: accept at cycle T, eng_start at T+1, busy seen at T+2, response in the cycle after busy falls.
- Fairness: a continuously requesting client waits at most N_REQ-1 operations.
- Operand hold: requesters may drop req_valid or change req_x after accept; the latched copy is used.
- Simultaneous accept and RESP cannot occur.
- A requester that deasserts req_valid before it is granted is simply skipped.

Optional Feature:
Macro CBRT_SCHED_CACHE_EN.
- When defined: one-entry cache holding {valid, x, root}.
  - Loaded in WAIT_DONE on a non-error completion.
  - Cleared by rst.
  - On accept in IDLE with valid & x==operand: go straight to RESP next cycle, no eng_start; latency 1 cycle after accept.
  - The grant and rr_ptr update happen exactly as on a miss.
- When undefined: no cache storage; every request goes through the engine.

Test Plan:
- Single requester 0, req_x=27 -> req_ready[0] pulse; eng_start one cycle later with eng_x=27; rsp_valid=0001, rsp_result=3, rsp_err=0.
- Requesters 0..3 all valid with x=8,0,255,7, held -> grant order 0,1,2,3; results 2,0,6,1; each rsp_valid one-hot to the correct owner; no overlap.
- Requesters 1 and 3 held valid continuously -> grants alternate 1,3,1,3; rr_ptr wraps correctly.
- Engine model that never raises busy -> after WD_CYC=4 cycles in WAIT_BUSY: rsp_valid to owner, rsp_err=1, rsp_result=0; next request served normally.
- rst asserted during WAIT_DONE -> next cycle all outputs 0, state IDLE, no rsp_valid; a following request x=64 returns 4.
- CBRT_SCHED_CACHE_EN defined: x=125 twice back-to-back -> first via engine (result 5); second gives no eng_start, rsp_valid the cycle after accept, result 5.
